// File: rtl/oneto4demux_stream_pkg.sv
// Shared types for the 1-to-4 stream demux: channel count, channel index
// and the packet-lock state encoding.
package oneto4demux_pkg;
    localparam int NCH = 4;

    typedef logic [1:0] ch_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;
endpackage

// File: rtl/oneto4demux_stream_if.sv
// Producer stream plus four per-channel consumer ports of the demux.
// The master modport is the producer/consumer side and the slave modport is the demux.
interface oneto4demux_stream_if #(parameter int n = 32);
    import oneto4demux_pkg::*;

    ch_t            sel;
    logic [n-1:0]   D;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [n-1:0]   out0;
    logic [n-1:0]   out1;
    logic [n-1:0]   out2;
    logic [n-1:0]   out3;
    logic [NCH-1:0] out_last;
    logic [NCH-1:0] out_valid;
    logic [NCH-1:0] out_ready;
    logic           busy;
    ch_t            route;

    modport master (
        output sel, D, in_valid, in_last, out_ready,
        input  in_ready, out0, out1, out2, out3, out_last, out_valid, busy, route
    );

    modport slave (
        input  sel, D, in_valid, in_last, out_ready,
        output in_ready, out0, out1, out2, out3, out_last, out_valid, busy, route
    );
endinterface

// File: rtl/oneto4demux_stream_slot.sv
// One output channel: a single-entry holding register with last and valid.
// A load in the same cycle as a drain wins, so valid stays high with new data.
module demux_slot #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         ready,
    input  logic [n-1:0] d,
    input  logic         last,
    output logic [n-1:0] q,
    output logic         q_last,
    output logic         q_valid
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q       <= '0;
            q_last  <= 1'b0;
            q_valid <= 1'b0;
        end else if (load) begin
            q       <= d;
            q_last  <= last;
            q_valid <= 1'b1;
        end else if (q_valid && ready) begin
            q_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/oneto4demux_stream.sv
// Registered 1-to-4 stream demux. With PKT_MODE=1 the route is locked from the
// first beat of a packet until its last beat so packets never split.
module oneto4demux_stream
    import oneto4demux_pkg::*;
#(
    parameter int n        = 32,
    parameter bit PKT_MODE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    oneto4demux_stream_if.slave   bus
);
    state_t                  state, state_nx;
    ch_t                     route_q, route_nx;
    ch_t                     tgt;
    logic                    rdy;
    logic                    acc;
    logic [NCH-1:0]          load;
    logic [NCH-1:0]          vld;
    logic [NCH-1:0]          lst;
    logic [NCH-1:0][n-1:0]   q;

    // sel is only honoured when no packet holds the route
    assign tgt = (PKT_MODE && state == LOCKED) ? route_q : bus.sel;
    assign rdy = ~vld[tgt] | bus.out_ready[tgt];
    assign acc = bus.in_valid & rdy;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_slot
            assign load[i] = acc && (tgt == ch_t'(i));
            demux_slot #(.n(n)) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (load[i]),
                .ready   (bus.out_ready[i]),
                .d       (bus.D),
                .last    (bus.in_last),
                .q       (q[i]),
                .q_last  (lst[i]),
                .q_valid (vld[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            route_q <= '0;
        end else begin
            state   <= state_nx;
            route_q <= route_nx;
        end
    end

    always_comb begin
        state_nx = state;
        route_nx = route_q;
        if (PKT_MODE) begin
            case (state)
                IDLE: begin
                    // single-beat packets never take the lock
                    if (acc && !bus.in_last) begin
                        state_nx = LOCKED;
                        route_nx = bus.sel;
                    end
                end
                LOCKED: begin
                    if (acc && bus.in_last) begin
                        state_nx = IDLE;
                        route_nx = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    route_nx = '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out_last  = lst;
    assign bus.out0      = q[0];
    assign bus.out1      = q[1];
    assign bus.out2      = q[2];
    assign bus.out3      = q[3];
    assign bus.busy      = (state == LOCKED);
    assign bus.route     = route_q;
endmodule
